miner_seq_ctrl: RTL and testbench



---
 rtl/miner_pkg.sv | 46 ++++
 rtl/miner_seq_ctrl_if.sv | 38 +++
 rtl/miner_hdr_buf.sv | 74 +++++++
 rtl/miner_seq_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_miner_seq_ctrl.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
//
// Shared definitions for the miner sequencing controller:
//   - state_t / ST_*   : controller FSM state encodings
//   - mint_t  / MINT_* : command codes driven on m_interrupt toward the miner
//   - HDR_WORDS_DEFAULT: number of 16-bit header words in one job (640 bits)
//   - abortable()      : which states a host abort is allowed to interrupt
//
// Optional feature macro used by this design: MINER_TIMEOUT_EN
// (RUN-state watchdog, see miner_seq_ctrl.sv).
// ---------------------------------------------------------------------------
package miner_pkg;

  localparam int HDR_WORDS_DEFAULT = 40;

  // FSM state encodings; plain constants so the encoding stays fixed
  // for tools and waveform scripts that predate enum support.
  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_MRST    = 4'd1;
  localparam state_t ST_LOAD    = 4'd2;
  localparam state_t ST_TURN    = 4'd3;
  localparam state_t ST_RUN     = 4'd4;
  localparam state_t ST_READ_HI = 4'd5;
  localparam state_t ST_READ_LO = 4'd6;
  localparam state_t ST_ABORT   = 4'd7;
  localparam state_t ST_DONE    = 4'd8;

  // Miner command codes presented on m_interrupt.
  typedef logic [1:0] mint_t;

  localparam mint_t MINT_NONE  = 2'b00;
  localparam mint_t MINT_LOAD  = 2'b01;
  localparam mint_t MINT_ABORT = 2'b10;
  localparam mint_t MINT_GO    = 2'b11;

  // A host abort only matters while the miner is being prepared or is
  // searching; once result words are being read the job is allowed to
  // complete normally, and in IDLE there is nothing to abort.
  function automatic logic abortable(input state_t s);
    return (s == ST_MRST) || (s == ST_LOAD) || (s == ST_TURN) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/miner_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// miner_seq_ctrl_if
//
// Host-side handshake bundle of the miner sequencing controller.
//   hdr_wr_en / hdr_wr_data : header word write strobe and data (host -> ctrl)
//   hdr_ready               : controller accepts a header word this cycle
//   start / abort           : job start and job abort requests (host -> ctrl)
//   busy                    : a job is in progress
//   done                    : one-cycle job-complete pulse
//   found / nonce_out       : result of the last job, valid from done to start
//   timeout                 : last job was ended by the watchdog
//
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface miner_seq_ctrl_if;

  logic        hdr_wr_en;
  logic [15:0] hdr_wr_data;
  logic        hdr_ready;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] nonce_out;
  logic        timeout;

  modport master (
    output hdr_wr_en, hdr_wr_data, start, abort,
    input  hdr_ready, busy, done, found, nonce_out, timeout
  );

  modport slave (
    input  hdr_wr_en, hdr_wr_data, start, abort,
    output hdr_ready, busy, done, found, nonce_out, timeout
  );

endinterface

// File: rtl/miner_hdr_buf.sv
// ---------------------------------------------------------------------------
// miner_hdr_buf
//
// Header register file for one mining job.
//   clk, rst   : clock and asynchronous active-low reset
//   wr_en      : accepted write (already qualified by the controller)
//   wr_data    : header word to store at the write pointer
//   clear      : drop the stored header (count and write pointer to 0)
//   rd_clear   : return the read index to word 0
//   rd_inc     : advance the read index by one word
//   count      : number of words currently held
//   rd_idx     : current read index
//   rd_data    : word at the read index (combinational)
//
// The storage array itself is not reset: its contents are only meaningful
// up to count, and count is reset.
// ---------------------------------------------------------------------------
module miner_hdr_buf
  import miner_pkg::*;
#(
  parameter  int HDR_WORDS = HDR_WORDS_DEFAULT,
  localparam int CW        = $clog2(HDR_WORDS + 1),
  localparam int IW        = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic          clear,
  input  logic          rd_clear,
  input  logic          rd_inc,
  output logic [CW-1:0] count,
  output logic [IW-1:0] rd_idx,
  output logic [15:0]   rd_data
);

  logic [15:0]   mem [HDR_WORDS];
  logic [IW-1:0] wr_ptr;

  // Fill level and write pointer advance together on every accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      count  <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      count  <= count + CW'(1);
      wr_ptr <= wr_ptr + IW'(1);
    end
  end

  // Word storage; no reset so it maps onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Read index walks the header from word 0 while the miner is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx <= '0;
    end else if (rd_clear) begin
      rd_idx <= '0;
    end else if (rd_inc) begin
      rd_idx <= rd_idx + IW'(1);
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/miner_seq_ctrl.sv
// ---------------------------------------------------------------------------
// miner_seq_ctrl
//
// Sequences one mining job on an external miner core: collects a header
// from the host, resets the miner, streams the header over the shared
// m_data bus, issues GO, waits for the search to finish and reads back a
// 32-bit nonce when one was found.
//
// Ports:
//   clk          : sole clock, all logic on the rising edge
//   rst          : asynchronous active-low reset
//   host         : host handshake bundle (miner_seq_ctrl_if.slave)
//   m_rst        : active-high miner reset
//   m_interrupt  : miner command (NONE / LOAD / ABORT / GO)
//   m_data       : shared 16-bit miner bus, driven here only in LOAD
//   m_mem_write  : miner is driving result words on m_data
//   m_valid      : miner search finished
//
// Parameters:
//   HDR_WORDS       : header length in 16-bit words
//   TIMEOUT_CYCLES  : RUN-state watchdog limit
//
// Optional feature macro: MINER_TIMEOUT_EN
//   defined   -> a RUN-cycle watchdog aborts the job after TIMEOUT_CYCLES
//                RUN cycles and flags timeout
//   undefined -> RUN waits indefinitely for the miner, timeout is tied 0
// ---------------------------------------------------------------------------
module miner_seq_ctrl
  import miner_pkg::*;
#(
  parameter int HDR_WORDS      = HDR_WORDS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                   clk,
  input  logic                   rst,
  miner_seq_ctrl_if.slave        host,
  output logic                   m_rst,
  output logic [1:0]             m_interrupt,
  inout  wire  [15:0]            m_data,
  input  logic                   m_mem_write,
  input  logic                   m_valid
);

  localparam int CW = $clog2(HDR_WORDS + 1);
  localparam int IW = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

  // The watchdog limit is only consumed when the watchdog is built in.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  state_t        state;
  state_t        state_nxt;
  logic          mrst_phase;
  logic          run_first;
  logic          rst_flag;
  logic          found_q;
  logic [31:0]   nonce_q;
  logic          timeout_q;
  logic          timeout_hit;

  logic [CW-1:0] hdr_count;
  logic [IW-1:0] rd_idx;
  logic [15:0]   rd_data;
  logic          hdr_ready_int;
  logic          wr_accept;
  logic          hdr_full;
  logic          last_word;
  logic          abort_req;
  logic          job_start;

  // Header writes are only taken in IDLE and only until the buffer is full;
  // anything else is dropped without touching the buffer.
  assign hdr_ready_int = (state == ST_IDLE) && (hdr_count < CW'(HDR_WORDS));
  assign wr_accept     = host.hdr_wr_en && hdr_ready_int;

  // start is judged against the registered count, so a write arriving in
  // the same cycle lands first and cannot make that same start succeed.
  assign hdr_full  = (hdr_count == CW'(HDR_WORDS));
  assign job_start = (state == ST_IDLE) && host.start && hdr_full;
  assign last_word = (rd_idx == IW'(HDR_WORDS - 1));
  assign abort_req = host.abort && abortable(state);

  miner_hdr_buf #(
    .HDR_WORDS (HDR_WORDS)
  ) u_hdr_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_accept),
    .wr_data  (host.hdr_wr_data),
    .clear    (state == ST_DONE),
    .rd_clear (state != ST_LOAD),
    .rd_inc   (state == ST_LOAD),
    .count    (hdr_count),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data)
  );

`ifdef MINER_TIMEOUT_EN
  logic [31:0] run_cnt;

  // Counts cycles spent in RUN; restarts from zero on every entry to RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (state == ST_RUN) begin
      run_cnt <= run_cnt + 32'd1;
    end else begin
      run_cnt <= '0;
    end
  end

  assign timeout_hit = (state == ST_RUN) && (run_cnt == 32'(TIMEOUT_CYCLES - 1));

  // The flag describes the last job: cleared by a new start, set only when
  // the watchdog (not a simultaneous host abort) ends the job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else if (job_start) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit && !host.abort) begin
      timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
`endif

  // Next-state logic. In RUN a host abort has priority over the miner
  // finishing in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (job_start) state_nxt = ST_MRST;
      end
      ST_MRST: begin
        if (abort_req)       state_nxt = ST_ABORT;
        else if (mrst_phase) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_req)      state_nxt = ST_ABORT;
        else if (last_word) state_nxt = ST_TURN;
      end
      ST_TURN: begin
        if (abort_req) state_nxt = ST_ABORT;
        else           state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort_req)        state_nxt = ST_ABORT;
        else if (timeout_hit) state_nxt = ST_ABORT;
        else if (m_valid)     state_nxt = m_mem_write ? ST_READ_HI : ST_DONE;
      end
      ST_READ_HI: state_nxt = ST_READ_LO;
      ST_READ_LO: state_nxt = ST_DONE;
      ST_ABORT:   state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register plus the small helpers that time MRST and the GO pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mrst_phase <= 1'b0;
      run_first  <= 1'b0;
    end else begin
      state      <= state_nxt;
      mrst_phase <= (state == ST_MRST) && !mrst_phase;
      run_first  <= (state == ST_TURN) && (state_nxt == ST_RUN);
    end
  end

  // Holds the miner in reset from the controller reset until the first
  // clock edge after it is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_flag <= 1'b1;
    end else begin
      rst_flag <= 1'b0;
    end
  end

  // Job result: found is cleared when a job starts and set only after both
  // nonce halves have been captured from the miner bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      found_q <= 1'b0;
      nonce_q <= '0;
    end else begin
      if (job_start) begin
        found_q <= 1'b0;
      end else if (state == ST_READ_LO) begin
        found_q <= 1'b1;
      end
      if (state == ST_READ_HI) begin
        nonce_q[31:16] <= m_data;
      end
      if (state == ST_READ_LO) begin
        nonce_q[15:0] <= m_data;
      end
    end
  end

  // Miner command decode; GO is a single-cycle command at the start of RUN.
  always_comb begin
    m_interrupt = MINT_NONE;
    case (state)
      ST_LOAD:  m_interrupt = MINT_LOAD;
      ST_ABORT: m_interrupt = MINT_ABORT;
      ST_RUN:   m_interrupt = run_first ? MINT_GO : MINT_NONE;
      default:  m_interrupt = MINT_NONE;
    endcase
  end

  assign m_rst  = rst_flag || (state == ST_MRST) || (state == ST_ABORT);
  assign m_data = (state == ST_LOAD) ? rd_data : 16'hzzzz;

  assign host.hdr_ready = hdr_ready_int;
  assign host.busy      = (state != ST_IDLE);
  assign host.done      = (state == ST_DONE);
  assign host.found     = found_q;
  assign host.nonce_out = nonce_q;
  assign host.timeout   = timeout_q;

endmodule

// File: tb/tb_miner_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_miner_seq_ctrl
//
// Self-checking bench for miner_seq_ctrl. Expected header words and job
// results are queued when a job is started; a negedge monitor pops and
// compares them as the controller streams words and pulses done.
// Optional feature macro exercised when defined: MINER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_miner_seq_ctrl;
  import miner_pkg::*;

  localparam int HW = 40;
  localparam int TO = 100;
  localparam int GO_LATENCY = 2 + HW + 1;

  typedef struct packed {
    logic        found;
    logic [31:0] nonce;
    logic        timeout;
  } result_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_rst;
  logic [1:0]  m_interrupt;
  wire  [15:0] m_data;
  logic        m_mem_write;
  logic        m_valid;
  logic [15:0] drv_data;
  logic        drv_en;

  int checks = 0;
  int errors = 0;

  logic [15:0] load_q [$];
  result_t     result_q [$];
  logic [15:0] hdr_model [$];
  logic [31:0] exp_nonce;
  logic [15:0] mon_word;
  result_t     mon_res;

  assign m_data = drv_en ? drv_data : 16'hzzzz;

  miner_seq_ctrl_if host_if ();

  miner_seq_ctrl #(
    .HDR_WORDS      (HW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (host_if),
    .m_rst       (m_rst),
    .m_interrupt (m_interrupt),
    .m_data      (m_data),
    .m_mem_write (m_mem_write),
    .m_valid     (m_valid)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: header words while LOAD is commanded, results on done.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (m_interrupt == MINT_LOAD) begin
        checks++;
        if (load_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL load_word: got %h, required no LOAD word", m_data);
        end else begin
          mon_word = load_q.pop_front();
          if (m_data !== mon_word) begin
            errors++;
            $display("[TB] FAIL load_word: got %h, required %h", m_data, mon_word);
          end
        end
      end
      if (host_if.done === 1'b1) begin
        checks++;
        if (result_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL done_pulse: got unexpected done, required none");
        end else begin
          mon_res = result_q.pop_front();
          if ({host_if.found, host_if.nonce_out, host_if.timeout} !== mon_res) begin
            errors++;
            $display("[TB] FAIL job_result: got found=%b nonce=%h timeout=%b, required found=%b nonce=%h timeout=%b",
                     host_if.found, host_if.nonce_out, host_if.timeout,
                     mon_res.found, mon_res.nonce, mon_res.timeout);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_header(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      host_if.hdr_wr_en   = 1'b1;
      host_if.hdr_wr_data = base + 16'(i);
      hdr_model.push_back(base + 16'(i));
      tick();
    end
    host_if.hdr_wr_en = 1'b0;
  endtask

  task automatic start_job();
    host_if.start = 1'b1;
    foreach (hdr_model[i]) load_q.push_back(hdr_model[i]);
    hdr_model.delete();
    tick();
    host_if.start = 1'b0;
  endtask

  task automatic wait_go(output int lat, output int mrst_n);
    lat    = 0;
    mrst_n = 0;
    while (m_interrupt !== MINT_GO && lat < 200) begin
      if (m_rst === 1'b1) mrst_n++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({host_if.busy, host_if.done, host_if.found, host_if.timeout, m_rst, host_if.hdr_ready, m_interrupt} !== 8'b0000_1100) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, required 00001100",
               {host_if.busy, host_if.done, host_if.found, host_if.timeout, m_rst, host_if.hdr_ready, m_interrupt});
    end
    checks++;
    if (host_if.nonce_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_nonce: got %h, required 00000000", host_if.nonce_out);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL m_rst_hold: got %b, required 1", m_rst);
    end
    tick();
    checks++;
    if (m_rst !== 1'b0 || host_if.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL m_rst_release: got m_rst=%b busy=%b, required 0 0", m_rst, host_if.busy);
    end
  endtask

  task automatic test_no_nonce();
    int lat, mr;
    load_header(HW, 16'hA000);
    start_job();
    wait_go(lat, mr);
    checks++;
    if (lat != GO_LATENCY || mr != 2) begin
      errors++;
      $display("[TB] FAIL go_latency_nn: got lat=%0d mrst=%0d, required %0d 2", lat, mr, GO_LATENCY);
    end
    result_q.push_back('{found: 1'b0, nonce: exp_nonce, timeout: 1'b0});
    tick();
    checks++;
    if (m_interrupt !== MINT_NONE) begin
      errors++;
      $display("[TB] FAIL go_one_cycle: got %b, required 00", m_interrupt);
    end
    m_valid     = 1'b1;
    m_mem_write = 1'b0;
    tick();
    m_valid = 1'b0;
    tick();
    checks++;
    if ({host_if.busy, host_if.found, host_if.hdr_ready} !== 3'b001 || host_if.nonce_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL no_nonce_idle: got busy=%b found=%b ready=%b nonce=%h, required 0 0 1 00000000",
               host_if.busy, host_if.found, host_if.hdr_ready, host_if.nonce_out);
    end
  endtask

  task automatic test_full_job();
    int lat, mr;
    load_header(HW, 16'h0000);
    start_job();
    wait_go(lat, mr);
    checks++;
    if (lat != GO_LATENCY || mr != 2) begin
      errors++;
      $display("[TB] FAIL go_latency_full: got lat=%0d mrst=%0d, required %0d 2", lat, mr, GO_LATENCY);
    end
    tick();
    exp_nonce = 32'hDEADBEEF;
    result_q.push_back('{found: 1'b1, nonce: exp_nonce, timeout: 1'b0});
    m_valid     = 1'b1;
    m_mem_write = 1'b1;
    drv_en      = 1'b1;
    drv_data    = 16'hDEAD;
    tick();
    m_valid     = 1'b0;
    m_mem_write = 1'b0;
    tick();
    drv_data = 16'hBEEF;
    tick();
    drv_en = 1'b0;
    tick();
    checks++;
    if (host_if.found !== 1'b1 || host_if.nonce_out !== 32'hDEADBEEF || host_if.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL result_hold: got found=%b nonce=%h busy=%b, required 1 deadbeef 0",
               host_if.found, host_if.nonce_out, host_if.busy);
    end
  endtask

  task automatic test_start_guard();
    int lat, mr;
    load_header(HW - 1, 16'h1000);
    host_if.start = 1'b1;
    tick();
    host_if.start = 1'b0;
    checks++;
    if (host_if.busy !== 1'b0 || host_if.hdr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_start: got busy=%b ready=%b, required 0 1", host_if.busy, host_if.hdr_ready);
    end
    load_header(1, 16'h1000 + 16'(HW - 1));
    host_if.hdr_wr_en   = 1'b1;
    host_if.hdr_wr_data = 16'hFFFF;
    tick();
    host_if.hdr_wr_en = 1'b0;
    checks++;
    if (host_if.hdr_ready !== 1'b0 || host_if.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_ready: got ready=%b busy=%b, required 0 0", host_if.hdr_ready, host_if.busy);
    end
    start_job();
    checks++;
    if (host_if.found !== 1'b0 || host_if.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_clears: got found=%b busy=%b, required 0 1", host_if.found, host_if.busy);
    end
    wait_go(lat, mr);
    checks++;
    if (lat != GO_LATENCY) begin
      errors++;
      $display("[TB] FAIL go_latency_guard: got %0d, required %0d", lat, GO_LATENCY);
    end
    host_if.hdr_wr_en   = 1'b1;
    host_if.hdr_wr_data = 16'hEEEE;
    #1;
    checks++;
    if (host_if.hdr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_ready: got %b, required 0", host_if.hdr_ready);
    end
    host_if.hdr_wr_en = 1'b0;
    tick();
    result_q.push_back('{found: 1'b0, nonce: exp_nonce, timeout: 1'b0});
    host_if.abort = 1'b1;
    m_valid       = 1'b1;
    m_mem_write   = 1'b1;
    tick();
    host_if.abort = 1'b0;
    m_valid       = 1'b0;
    m_mem_write   = 1'b0;
    checks++;
    if (m_interrupt !== MINT_ABORT || m_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_wins: got int=%b m_rst=%b, required 10 1", m_interrupt, m_rst);
    end
    tick();
    tick();
  endtask

  task automatic test_write_start_same_cycle();
    int lat, mr;
    load_header(HW - 1, 16'h2000);
    host_if.hdr_wr_en   = 1'b1;
    host_if.hdr_wr_data = 16'h2000 + 16'(HW - 1);
    hdr_model.push_back(16'h2000 + 16'(HW - 1));
    host_if.start = 1'b1;
    tick();
    host_if.hdr_wr_en = 1'b0;
    host_if.start     = 1'b0;
    checks++;
    if (host_if.busy !== 1'b0 || host_if.hdr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_start: got busy=%b ready=%b, required 0 0", host_if.busy, host_if.hdr_ready);
    end
    start_job();
    wait_go(lat, mr);
    checks++;
    if (lat != GO_LATENCY) begin
      errors++;
      $display("[TB] FAIL go_latency_ws: got %0d, required %0d", lat, GO_LATENCY);
    end
    exp_nonce = 32'h13572468;
    result_q.push_back('{found: 1'b1, nonce: exp_nonce, timeout: 1'b0});
    m_valid     = 1'b1;
    m_mem_write = 1'b1;
    drv_en      = 1'b1;
    drv_data    = 16'h1357;
    tick();
    m_valid     = 1'b0;
    m_mem_write = 1'b0;
    tick();
    drv_data = 16'h2468;
    tick();
    drv_en = 1'b0;
    tick();
  endtask

  task automatic test_abort_load();
    int n;
    load_header(HW, 16'h3000);
    start_job();
    n = 0;
    while (m_interrupt !== MINT_LOAD && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (m_interrupt !== MINT_LOAD) begin
      errors++;
      $display("[TB] FAIL reach_load: got %b, required 01", m_interrupt);
    end
    repeat (9) tick();
    result_q.push_back('{found: 1'b0, nonce: exp_nonce, timeout: 1'b0});
    host_if.abort = 1'b1;
    tick();
    host_if.abort = 1'b0;
    checks++;
    if (load_q.size() != HW - 10) begin
      errors++;
      $display("[TB] FAIL words_before_abort: got %0d left, required %0d", load_q.size(), HW - 10);
    end
    load_q.delete();
    checks++;
    if (m_interrupt !== MINT_ABORT || m_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_load: got int=%b m_rst=%b, required 10 1", m_interrupt, m_rst);
    end
    tick();
    tick();
    drv_en   = 1'b1;
    drv_data = 16'h5A5A;
    #1;
    checks++;
    if (m_data !== 16'h5A5A) begin
      errors++;
      $display("[TB] FAIL bus_released: got %h, required 5a5a", m_data);
    end
    drv_en = 1'b0;
  endtask

`ifdef MINER_TIMEOUT_EN
  task automatic test_timeout();
    int lat, mr, n;
    load_header(HW, 16'h4000);
    start_job();
    wait_go(lat, mr);
    result_q.push_back('{found: 1'b0, nonce: exp_nonce, timeout: 1'b1});
    n = 0;
    while (m_interrupt !== MINT_ABORT && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n != TO || m_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_cycles: got %0d m_rst=%b, required %0d 1", n, m_rst, TO);
    end
    tick();
    tick();
    checks++;
    if (host_if.timeout !== 1'b1 || host_if.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_flag: got timeout=%b busy=%b, required 1 0", host_if.timeout, host_if.busy);
    end
  endtask
`else
  task automatic test_run_wait();
    int lat, mr;
    load_header(HW, 16'h4000);
    start_job();
    wait_go(lat, mr);
    result_q.push_back('{found: 1'b0, nonce: exp_nonce, timeout: 1'b0});
    repeat (300) tick();
    checks++;
    if (host_if.busy !== 1'b1 || m_interrupt !== MINT_NONE || host_if.timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_wait: got busy=%b int=%b timeout=%b, required 1 00 0",
               host_if.busy, m_interrupt, host_if.timeout);
    end
    host_if.abort = 1'b1;
    tick();
    host_if.abort = 1'b0;
    tick();
    tick();
  endtask
`endif

  task automatic test_reset_mid_run();
    int lat, mr;
    load_header(HW, 16'h5000);
    start_job();
    wait_go(lat, mr);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    exp_nonce = 32'h0;
    checks++;
    if ({host_if.busy, host_if.done, host_if.found, host_if.timeout, m_rst, host_if.hdr_ready, m_interrupt} !== 8'b0000_1100
        || host_if.nonce_out !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_run_reset: got %b nonce=%h, required 00001100 00000000",
               {host_if.busy, host_if.done, host_if.found, host_if.timeout, m_rst, host_if.hdr_ready, m_interrupt},
               host_if.nonce_out);
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (m_rst !== 1'b0 || host_if.hdr_ready !== 1'b1 || host_if.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset: got m_rst=%b ready=%b busy=%b, required 0 1 0",
               m_rst, host_if.hdr_ready, host_if.busy);
    end
    repeat (5) tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst                 = 1'b0;
    host_if.hdr_wr_en   = 1'b0;
    host_if.hdr_wr_data = 16'h0;
    host_if.start       = 1'b0;
    host_if.abort       = 1'b0;
    m_valid             = 1'b0;
    m_mem_write         = 1'b0;
    drv_en              = 1'b0;
    drv_data            = 16'h0;
    exp_nonce           = 32'h0;

    test_reset();
    test_no_nonce();
    test_full_job();
    test_start_guard();
    test_write_start_same_cycle();
    test_abort_load();
`ifdef MINER_TIMEOUT_EN
    test_timeout();
`else
    test_run_wait();
`endif
    test_reset_mid_run();

    checks++;
    if (load_q.size() != 0 || result_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d words %0d results pending, required 0 0",
               load_q.size(), result_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
